// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 serial UART receiver, LSB first (8E1 with even parity when
//           the optional UART_RX_PARITY_EN macro is defined).
//
// The asynchronous rx pin is oversampled with clk. Each frame is
// deserialised and the byte is presented on data, together with a
// one-cycle write_trig that feeds the downstream RX byte FIFO directly.
// There is no backpressure: the FIFO overwrites its oldest entry when full.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit period (8..65535, even preferred)
//   CNT_BITS      width of the bit-timing counter
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset       in   asynchronous active-high reset
//   rx          in   raw serial line, idle high, asynchronous to clk
//   data        out  [7:0] last correctly received byte
//   write_trig  out  one-cycle pulse, data valid this cycle
//   frame_err   out  one-cycle pulse, stop bit sampled low
//   parity_err  out  one-cycle pulse on parity mismatch (0 without parity)
//   busy        out  high whenever the receiver is not idle
//
// Optional feature macro: UART_RX_PARITY_EN (even parity, 8E1 framing).
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_BITS     = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       write_trig,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam logic [CNT_BITS-1:0] HALF_LOAD = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_BITS-1:0] FULL_LOAD = CNT_BITS'(CLKS_PER_BIT - 1);

    state_t              state, state_n;
    logic [CNT_BITS-1:0] cnt, cnt_n;
    logic [2:0]          bit_idx, idx_n;
    logic [7:0]          shreg, shreg_n;
    logic [7:0]          data_n;
    logic                wt_n, fe_n;
    logic                rx_m, rx_s, rx_q;
    logic                tick;

    // Synchroniser flops preset to 1 so reset release looks like an idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    assign tick = (cnt == '0);
    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
    logic pe_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= pe_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            write_trig <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= idx_n;
            shreg      <= shreg_n;
            data       <= data_n;
            write_trig <= wt_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        shreg_n = shreg;
        data_n  = data;
        wt_n    = 1'b0;
        fe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        pe_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_q && !rx_s) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = FULL_LOAD;
                        idx_n   = 3'd0;
                    end
                end else begin
                    cnt_n = cnt - CNT_BITS'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = FULL_LOAD;
                    idx_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt - CNT_BITS'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    // Even parity: data bits XOR parity bit must be zero.
                    par_bad_n = ^{shreg, rx_s};
                    cnt_n     = FULL_LOAD;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt - CNT_BITS'(1);
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // Leave at mid stop bit so a half-bit stop still allows
                    // back-to-back frames.
                    if (rx_s) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            pe_n = 1'b1;
                        end else begin
                            wt_n   = 1'b1;
                            data_n = shreg;
                        end
`else
                        wt_n   = 1'b1;
                        data_n = shreg;
`endif
                    end else begin
                        fe_n    = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt - CNT_BITS'(1);
                end
            end
            BREAK: begin
                // Wait out a held-low line before start detection resumes.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Directed frames come from a vector table; glitch and mid-frame reset are
// hand-written sequences; a randomized run is checked against a frame-level
// reference model (per frame: stop good -> byte or parity error, stop bad ->
// framing error, data register keeps the last good byte).
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT  = PAR_EN ? 172 : 156;
    localparam int K_WT = 0;
    localparam int K_FE = 1;
    localparam int K_PE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       write_trig;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .write_trig (write_trig),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        bit         par_flip;
        int         kind;
        logic [7:0] d_exp;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  t_fall = 0;
    bit  prev_pulse = 1'b0;
    ev_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Output monitor: records every pulse and checks exclusivity/isolation.
    always @(negedge clk) begin : mon
        ev_t e;
        if (write_trig || frame_err || parity_err) begin
            chk((int'(write_trig) + int'(frame_err) + int'(parity_err)) == 1 && !prev_pulse,
                "pulse_isolated", {29'd0, write_trig, frame_err, parity_err}, 0);
            e.kind = write_trig ? K_WT : (frame_err ? K_FE : K_PE);
            e.d    = data;
            e.cyc  = cyc;
            obs_q.push_back(e);
        end
        prev_pulse = write_trig | frame_err | parity_err;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_low,
                              input bit par_flip, input bit chk_busy);
        logic pb;
        pb     = (^b) ^ par_flip;
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            if (chk_busy) chk(busy === 1'b1, "busy_in_frame", int'(busy), 1);
        end
        if (PAR_EN) drive_bit(pb);
        if (!stop_ok) begin
            repeat (stop_low) drive_bit(1'b0);
        end
        drive_bit(1'b1);
    endtask

    task automatic check_frame(input int kind_exp, input logic [7:0] d_exp,
                               input string nm, output int ev_cyc);
        ev_t e;
        ev_cyc = -1;
        chk(obs_q.size() == 1, {nm, "_event_count"}, obs_q.size(), 1);
        if (obs_q.size() >= 1) begin
            e      = obs_q.pop_front();
            ev_cyc = e.cyc;
            chk(e.kind == kind_exp, {nm, "_event_kind"}, e.kind, kind_exp);
            chk(e.d === d_exp, {nm, "_event_data"}, int'(e.d), int'(d_exp));
        end
        obs_q.delete();
        chk(data === d_exp, {nm, "_data_out"}, int'(data), int'(d_exp));
    endtask

    vec_t       vecs[8];
    int         nv;
    int         ec;
    int         n;
    logic [7:0] model_data;
    logic [7:0] b;
    bit         ok;
    bit         flip;
    int         kind;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, K_WT, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1'b0, K_WT, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, K_WT, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, K_WT, 8'h3C};
        vecs[4] = '{8'h81, 1'b0, 1'b0, K_FE, 8'h3C};
        vecs[5] = '{8'h42, 1'b1, 1'b0, K_WT, 8'h42};
        vecs[6] = '{8'h03, 1'b1, 1'b0, K_WT, 8'h03};
        vecs[7] = '{8'h03, 1'b1, 1'b1, K_PE, 8'h03};
        nv = PAR_EN ? 8 : 6;

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        chk(data === 8'h00, "reset_data", int'(data), 0);
        chk({write_trig, frame_err, parity_err} === 3'b000, "reset_pulses",
            int'({write_trig, frame_err, parity_err}), 0);
        chk(busy === 1'b0, "reset_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (CPB) @(posedge clk);
        #2;

        // Directed table
        for (int i = 0; i < nv; i++) begin
            send_frame(vecs[i].b, vecs[i].stop_ok, 3, vecs[i].par_flip, i == 0);
            check_frame(vecs[i].kind, vecs[i].d_exp, $sformatf("vec%0d", i), ec);
            if (i == 0) begin
                chk(ec - t_fall >= LAT - 1 && ec - t_fall <= LAT + 1, "latency",
                    ec - t_fall, LAT);
            end
        end
        model_data = vecs[nv-1].d_exp;

        // Short glitch while idle
        repeat (CPB) @(posedge clk);
        #2;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rx = 1'b1;
        @(negedge clk);
        chk(busy === 1'b1, "glitch_busy_high", int'(busy), 1);
        n = 0;
        while (busy === 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk(busy === 1'b0 && n <= 9, "glitch_busy_low_cycles", n, 9);
        chk(obs_q.size() == 0, "glitch_no_pulse", obs_q.size(), 0);
        obs_q.delete();
        @(posedge clk);
        #2;
        drive_bit(1'b1);
        send_frame(8'h55, 1'b1, 0, 1'b0, 1'b0);
        check_frame(K_WT, 8'h55, "after_glitch", ec);

        // Reset 5 bit periods into a frame
        b = 8'h99;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        chk(busy === 1'b1, "midframe_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk(data === 8'h00, "midreset_data", int'(data), 0);
        chk({write_trig, frame_err, parity_err, busy} === 4'b0000, "midreset_outputs",
            int'({write_trig, frame_err, parity_err, busy}), 0);
        repeat (3) @(posedge clk);
        #2;
        rx    = 1'b1;
        reset = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk(obs_q.size() == 0, "aborted_frame_no_pulse", obs_q.size(), 0);
        obs_q.delete();
        send_frame(8'h12, 1'b1, 0, 1'b0, 1'b0);
        check_frame(K_WT, 8'h12, "after_reset", ec);
        model_data = 8'h12;

        // Randomized frames against the frame-level model
        for (int i = 0; i < 40; i++) begin
            b    = 8'($urandom);
            ok   = ($urandom_range(0, 7) != 0);
            flip = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!ok) begin
                kind = K_FE;
            end else if (flip) begin
                kind = K_PE;
            end else begin
                kind       = K_WT;
                model_data = b;
            end
            send_frame(b, ok, int'($urandom_range(1, 3)), flip, 1'b0);
            check_frame(kind, model_data, $sformatf("rand%0d", i), ec);
            rx = 1'b1;
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #2;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first. It sits directly upstream of the RX byte FIFO.
- Oversamples the asynchronous `rx` pin with the system clock, deserialises each frame and presents the byte on `data`.
- Emits a single-cycle `write_trig` that drives the FIFO's write_trig/in pair directly.
- Flags framing errors and tracks line activity for the bus-side status register.

Parameters:
- CLKS_PER_BIT, 104, system clocks per bit period (12 MHz / 115200). Legal range 8..65535; an even value is recommended.
- CNT_BITS, $clog2(CLKS_PER_BIT), width of the bit-timing counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset. It clears all state immediately and releases synchronously to clk.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- data  output  8  last correctly received byte; stable from write_trig until the next write_trig.
- write_trig  output  1  one-clock pulse: data is valid this cycle (drives FIFO write_trig).
- frame_err  output  1  one-clock pulse: stop bit sampled low.
- parity_err  output  1  one-clock pulse on parity mismatch. It is constant 0 unless UART_RX_PARITY_EN is defined.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - data=0, write_trig=0, frame_err=0, parity_err=0, busy=0, FSM=IDLE.
  - Both synchroniser flops are set to 1 (line idle), so the release of reset never creates a false start.
- Input path: `rx` passes through a 2-flop synchroniser to give rx_s; rx_q is the one-cycle-delayed rx_s. All decisions use rx_s only.
- IDLE:
  - A falling edge (rx_q=1, rx_s=0) moves the FSM to START and loads cnt = CLKS_PER_BIT/2 - 1.
- START:
  - cnt decrements each clock. At cnt==0, rx_s is sampled (mid start bit).
  - rx_s=1: false start; return to IDLE, no outputs.
  - rx_s=0: go to DATA with cnt = CLKS_PER_BIT-1 and bit index = 0.
- DATA:
  - At each cnt==0, rx_s shifts into shreg[7] with a right shift, so the LSB arrives first.
  - The counter reloads to CLKS_PER_BIT-1 after each bit.
  - After bit index 7, go to STOP (or PARITY, see Optional Feature) with a reload.
- STOP: at cnt==0, rx_s is sampled (mid stop bit).
  - rx_s=1: next cycle data<=shreg and write_trig=1 for exactly one clock; FSM to IDLE.
  - rx_s=0: next cycle frame_err=1 for one clock; data is unchanged, no write_trig; FSM to BREAK.
- BREAK: hold until rx_s=1, then go to IDLE. No start detection happens while in BREAK.
- Timing:
  - Returning to IDLE at mid-stop permits back-to-back frames with a stop length of ≥0.5 bit.
  - Sample points fall at start-detect + CLKS_PER_BIT/2 + k*CLKS_PER_BIT for k=0..9.
  - write_trig asserts one clock after the k=9 sample.
  - Pin-to-detect latency is 3 clocks.
- Constraints and boundaries:
  - write_trig, frame_err and parity_err are mutually exclusive and never assert in consecutive cycles.
  - A glitch on rx shorter than CLKS_PER_BIT/2 clocks while in IDLE causes a false start only (no outputs).
  - Asserting reset mid-frame discards the frame; no pulse is emitted.
  - After reset, the receiver needs rx_s high followed by a falling edge before it will start.
  - There is no backpressure. The FIFO downstream overwrites its oldest entry when full, so uart_rx never stalls.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Even parity; the frame becomes 8E1.
  - A PARITY state between DATA and STOP samples one extra bit, and the expected parity is the XOR of the 8 data bits and the parity bit = 0.
  - On mismatch, STOP is still sampled. If the stop bit is good, parity_err pulses instead of write_trig and the byte is dropped. If the stop bit is bad, frame_err takes precedence.
  - write_trig then occurs one clock after the k=10 sample.
- Not defined: no PARITY state, parity_err tied 0, 8N1 timing as above.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (8N1), stop bit 1 → exactly one write_trig with data=0xA5, 3+8+144+1=156 clocks ±1 after the rx falling edge; busy high during the frame.
- Send 0x00, then 0xFF back-to-back with a 1-bit stop, then 0x3C with a 1-bit stop → three write_trig pulses, data=0x00, 0xFF, 0x3C in order, no errors.
- 4-clock low glitch on rx while idle → no write_trig, no frame_err; busy returns low within 9 clocks; a following 0x55 is received correctly.
- Send 0x81 with the stop bit held 0 for 3 bit periods, then high, then 0x42 → frame_err pulse once, data stays at its prior value; 0x42 is then received with write_trig.
- Assert reset 5 bit periods into 0x99, release it, then send 0x12 → no pulse for 0x99, all outputs 0 during reset, 0x12 received.
- UART_RX_PARITY_EN: send 0x03 with parity bit 0, then with parity bit 1 → first: write_trig, data=0x03; second: parity_err pulse, no write_trig.
